// File: rtl/fetch_issue_unit.sv
// Fetch/issue stage: owns the PC, fetches over a req/valid handshake and issues
// decoded fields through a single output slot backed by a one-entry hold buffer.
module fetch_issue_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [5:0]         opcode,
    output logic [4:0]         rd,
    output logic [4:0]         rs1,
    output logic [4:0]         rs2,
    output logic [15:0]        imm_raw,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               illegal
);

    typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d, pc_next;
    logic                req_q, req_d;
    logic [INSTR_W-1:0]  hold_word_q, hold_word_d;
    logic [ADDR_W-1:0]   hold_pc_q, hold_pc_d;

    logic                valid_q, valid_d, illegal_q, illegal_d;
    logic [5:0]          op_q, op_d;
    logic [4:0]          rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [15:0]         imm_q, imm_d;
    logic [ADDR_W-1:0]   out_pc_q, out_pc_d;

    logic                load_en, slot_clear;
    logic [INSTR_W-1:0]  load_word;
    logic [ADDR_W-1:0]   load_pc;
    logic [5:0]          load_op;

    function automatic logic opcode_legal(input logic [5:0] op);
        case (op)
            6'b000000, 6'b000001, 6'b001001, 6'b000010, 6'b001010, 6'b000011,
            6'b001011, 6'b000100, 6'b001100, 6'b010001, 6'b011001, 6'b010010,
            6'b011010, 6'b010011, 6'b010100, 6'b101001, 6'b101010, 6'b101011,
            6'b111000, 6'b111001, 6'b111010, 6'b111011, 6'b111100, 6'b111101,
            6'b111110: opcode_legal = 1'b1;
            default:   opcode_legal = 1'b0;
        endcase
    endfunction

    assign pc_next = pc_q + ADDR_W'(PC_STEP);
    assign load_op = load_word[INSTR_W-1 -: 6];

    // Fetch control: redirect overrides everything; an in-flight request forces a drain.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_d       = req_q;
        hold_word_d = hold_word_q;
        hold_pc_d   = hold_pc_q;
        load_en     = 1'b0;
        load_word   = imem_rdata;
        load_pc     = pc_q;
        if (redirect) begin
            pc_d        = redirect_pc;
            hold_word_d = '0;
            hold_pc_d   = '0;
            if ((((state_q == StFetch) && req_q) || (state_q == StDrain)) && !imem_valid) begin
                state_d = StDrain;
                req_d   = 1'b0;
            end else begin
                state_d = StFetch;
                req_d   = 1'b1;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StFetch;
                    req_d   = 1'b1;
                end
                StFetch: begin
                    if (!req_q) begin
                        req_d = 1'b1;
                    end else if (imem_valid) begin
                        req_d = 1'b0;
                        pc_d  = pc_next;
                        if (!valid_q || out_ready) begin
                            load_en = 1'b1;
                        end else begin
                            hold_word_d = imem_rdata;
                            hold_pc_d   = pc_q;
                            state_d     = StHold;
                        end
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        load_en   = 1'b1;
                        load_word = hold_word_q;
                        load_pc   = hold_pc_q;
                        state_d   = StFetch;
                        req_d     = 1'b1;
                    end
                end
                StDrain: begin
                    if (imem_valid) begin
                        state_d = StFetch;
                        req_d   = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Issue slot: illegal opcodes are replaced by a zeroed NOP with the flag set.
    always_comb begin
        valid_d    = valid_q;
        op_d       = op_q;
        rd_d       = rd_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        imm_d      = imm_q;
        illegal_d  = illegal_q;
        out_pc_d   = out_pc_q;
        slot_clear = redirect || (!load_en && valid_q && out_ready);
        if (slot_clear) begin
            valid_d   = 1'b0;
            op_d      = '0;
            rd_d      = '0;
            rs1_d     = '0;
            rs2_d     = '0;
            imm_d     = '0;
            illegal_d = 1'b0;
        end else if (load_en) begin
            valid_d  = 1'b1;
            out_pc_d = load_pc;
            if (opcode_legal(load_op)) begin
                op_d      = load_op;
                rd_d      = load_word[25:21];
                rs1_d     = load_word[20:16];
                rs2_d     = load_word[15:11];
                imm_d     = load_word[15:0];
                illegal_d = 1'b0;
            end else begin
                op_d      = '0;
                rd_d      = '0;
                rs1_d     = '0;
                rs2_d     = '0;
                imm_d     = '0;
                illegal_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            req_q       <= 1'b0;
            hold_word_q <= '0;
            hold_pc_q   <= '0;
            valid_q     <= 1'b0;
            op_q        <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            illegal_q   <= 1'b0;
            out_pc_q    <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_q       <= req_d;
            hold_word_q <= hold_word_d;
            hold_pc_q   <= hold_pc_d;
            valid_q     <= valid_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            imm_q       <= imm_d;
            illegal_q   <= illegal_d;
            out_pc_q    <= out_pc_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign out_valid = valid_q;
    assign opcode    = op_q;
    assign rd        = rd_q;
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign imm_raw   = imm_q;
    assign out_pc    = out_pc_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Bench for fetch_issue_unit: a behavioural imem answers requests; expected issue records
// are queued when a word is accepted and compared when decode consumes the slot.
module tb_fetch_issue_unit;

    localparam logic [5:0] LEGAL_OPS [18] = '{
        6'b000000, 6'b000001, 6'b001001, 6'b000010, 6'b001010, 6'b000011,
        6'b001011, 6'b000100, 6'b001100, 6'b010001, 6'b011001, 6'b010010,
        6'b011010, 6'b010011, 6'b010100, 6'b101001, 6'b101010, 6'b101011};
    localparam logic [5:0] TEST_OPS [8] = '{
        6'b000001, 6'b111111, 6'b000010, 6'b000101,
        6'b111110, 6'b100000, 6'b101011, 6'b011111};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req, imem_valid, out_valid, illegal;
    logic [31:0] imem_addr, imem_rdata, out_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_ready = 1'b0;
    logic [5:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [15:0] imm_raw;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem [0:63];
    logic        auto_on = 1'b0;
    int unsigned auto_lat = 0;
    logic [31:0] auto_limit = '1;
    int unsigned req_cnt;
    logic        man_valid = 1'b0;
    logic [69:0] sb [$];

    fetch_issue_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .opcode      (opcode),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .imm_raw     (imm_raw),
        .out_pc      (out_pc),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[7:2]];
    assign imem_valid = man_valid |
        (auto_on && imem_req && (req_cnt == auto_lat) && (imem_addr < auto_limit));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_cnt <= 0;
        else if (!imem_req || imem_valid) req_cnt <= 0;
        else req_cnt <= req_cnt + 1;
    end

    function automatic bit tb_legal(input logic [5:0] op);
        if (op >= 6'b111000 && op <= 6'b111110) return 1'b1;
        foreach (LEGAL_OPS[k]) if (LEGAL_OPS[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    // {opcode, rd, rs1, rs2, imm, pc, illegal}
    function automatic logic [69:0] expect_rec(input logic [31:0] w, input logic [31:0] pc);
        if (tb_legal(w[31:26]))
            return {w[31:26], w[25:21], w[20:16], w[15:11], w[15:0], pc, 1'b0};
        return {37'd0, pc, 1'b1};
    endfunction

    always @(negedge clk) begin : monitor
        logic [69:0] act, exp_rec;
        if (rst_n) begin
            act = {opcode, rd, rs1, rs2, imm_raw, out_pc, illegal};
            if (!out_valid) begin
                checks++;
                if ({opcode, rd, rs1, rs2, imm_raw, illegal} !== 38'd0) begin
                    errors++;
                    $display("FAIL idle_fields: got %h, want 0",
                             {opcode, rd, rs1, rs2, imm_raw, illegal});
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: issued rec %h, want nothing issued", act);
                end else begin
                    exp_rec = sb.pop_front();
                    if (act !== exp_rec) begin
                        errors++;
                        $display("FAIL sb_issue: got %h, want %h", act, exp_rec);
                    end
                end
            end
            if (redirect) sb.delete();
            else if (imem_valid && imem_req) sb.push_back(expect_rec(imem_rdata, imem_addr));
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        redirect = 1'b0;
        man_valid = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 64; i++) mem[i] = {6'b000001, 5'(i), 5'(i + 1), 5'(i + 2), 11'(i)};
    endtask

    task automatic drain_and_check(input string tag);
        auto_limit = '0;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!out_valid) break;
        end
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending / out_valid=%b, want 0 / 0",
                     tag, sb.size(), out_valid);
        end
        auto_on = 1'b0;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL rst_req: got %b, want 0", imem_req);
        end
        checks++;
        if (imem_addr !== 32'd0) begin
            errors++; $display("FAIL rst_addr: got %h, want 0", imem_addr);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_valid: got %b, want 0", out_valid);
        end
        checks++;
        if ({opcode, rd, rs1, rs2, imm_raw} !== 37'd0) begin
            errors++; $display("FAIL rst_fields: got %h, want 0", {opcode, rd, rs1, rs2, imm_raw});
        end
        checks++;
        if (out_pc !== 32'd0 || illegal !== 1'b0) begin
            errors++; $display("FAIL rst_pc_ill: got %h/%b, want 0/0", out_pc, illegal);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL idle_cycle_req: got %b, want 0", imem_req);
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            errors++; $display("FAIL first_req: got %b@%h, want 1@0", imem_req, imem_addr);
        end
    endtask

    task automatic test_basic();
        logic [31:0] addrs [3];
        int          cyc [3];
        int          n = 0;
        bit          seen = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h04221800;
        auto_on = 1'b1; auto_lat = 0; auto_limit = '1; out_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 40 && n < 3; c++) begin
            @(negedge clk);
            if (imem_req && imem_valid) begin
                addrs[n] = imem_addr; cyc[n] = c; n++;
            end
            if (out_valid && !seen) begin
                seen = 1'b1;
                checks++;
                if ({opcode, rd, rs1, rs2, out_pc} !== {6'b000001, 5'd1, 5'd2, 5'd3, 32'd0}) begin
                    errors++;
                    $display("FAIL basic_first: got %h, want %h", {opcode, rd, rs1, rs2, out_pc},
                             {6'b000001, 5'd1, 5'd2, 5'd3, 32'd0});
                end
            end
        end
        checks++;
        if (n != 3 || !seen) begin
            errors++; $display("FAIL basic_count: got %0d reqs seen=%b, want 3 reqs seen=1", n, seen);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (addrs[i] !== 32'(i * 4)) begin
                    errors++; $display("FAIL basic_addr%0d: got %h, want %h", i, addrs[i], i * 4);
                end
            end
            checks++;
            if (cyc[1] - cyc[0] != 2 || cyc[2] - cyc[1] != 2) begin
                errors++;
                $display("FAIL basic_spacing: got %0d,%0d, want 2,2", cyc[1] - cyc[0], cyc[2] - cyc[1]);
            end
        end
        drain_and_check("basic");
    endtask

    task automatic test_stall();
        fill_mem();
        auto_on = 1'b1; auto_lat = 0; auto_limit = '1; out_ready = 1'b0;
        do_reset();
        repeat (6) @(negedge clk);
        checks++;
        if ({out_valid, out_pc, imem_req, rd} !== {1'b1, 32'd0, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL stall_hold: got v=%b pc=%h req=%b rd=%0d, want v=1 pc=0 req=0 rd=0",
                     out_valid, out_pc, imem_req, rd);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, out_pc, rd} !== {1'b1, 32'd4, 5'd1}) begin
            errors++;
            $display("FAIL stall_release: got v=%b pc=%h rd=%0d, want v=1 pc=4 rd=1",
                     out_valid, out_pc, rd);
        end
        repeat (8) @(negedge clk);
        drain_and_check("stall");
    endtask

    task automatic test_redirect_drain();
        bit found = 1'b0;
        fill_mem();
        auto_on = 1'b1; auto_lat = 0; auto_limit = 32'h8; out_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h8) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL rd_wait_req8: got timeout, want request to 0x8");
        end
        @(posedge clk);
        #1 redirect = 1'b1; redirect_pc = 32'h40;
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rd_drain: got req=%b v=%b, want 0/0", imem_req, out_valid);
        end
        @(posedge clk);
        @(posedge clk);
        #1 man_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL rd_drain_req: got %b, want 0", imem_req);
        end
        @(posedge clk);
        #1 man_valid = 1'b0; auto_limit = '1;
        @(negedge clk);
        checks++;
        if ({imem_req, imem_addr, out_valid} !== {1'b1, 32'h40, 1'b0}) begin
            errors++;
            $display("FAIL rd_refetch: got req=%b addr=%h v=%b, want 1/40/0",
                     imem_req, imem_addr, out_valid);
        end
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) begin found = (out_pc == 32'h40); break; end
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL rd_target_issue: got pc=%h, want 40", out_pc);
        end
        drain_and_check("redirect");
    endtask

    task automatic test_illegal();
        bit f4 = 1'b0, f8 = 1'b0, f28 = 1'b0;
        fill_mem();
        for (int i = 0; i < 8; i++)
            mem[i] = {TEST_OPS[i], 5'(i + 3), 5'(i + 7), 5'(i + 1), 11'(i * 3)};
        auto_on = 1'b1; auto_lat = 1; auto_limit = '1; out_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 80 && !f28; c++) begin
            @(negedge clk);
            if (out_valid && out_pc == 32'h4 && !f4) begin
                f4 = 1'b1;
                checks++;
                if ({opcode, rd, imm_raw, illegal} !== {6'd0, 5'd0, 16'd0, 1'b1}) begin
                    errors++;
                    $display("FAIL ill_nop: got op=%b rd=%0d imm=%h ill=%b, want 0/0/0/1",
                             opcode, rd, imm_raw, illegal);
                end
            end
            if (out_valid && out_pc == 32'h8 && !f8) begin
                f8 = 1'b1;
                checks++;
                if ({opcode, illegal} !== {6'b000010, 1'b0}) begin
                    errors++;
                    $display("FAIL ill_clear: got op=%b ill=%b, want 000010/0", opcode, illegal);
                end
            end
            if (out_valid && out_pc == 32'h1c) f28 = 1'b1;
        end
        checks++;
        if (!(f4 && f8 && f28)) begin
            errors++; $display("FAIL ill_progress: got %b%b%b, want 111", f4, f8, f28);
        end
        drain_and_check("illegal");
    endtask

    task automatic test_async_reset();
        bit found = 1'b0;
        fill_mem();
        auto_on = 1'b1; auto_lat = 0; auto_limit = '1; out_ready = 1'b0;
        do_reset();
        repeat (6) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || imem_req !== 1'b0) begin
            errors++; $display("FAIL ar_pre: got v=%b req=%b, want 1/0", out_valid, imem_req);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        checks++;
        if ({imem_req, imem_addr, out_valid, opcode, rd, rs1, rs2, imm_raw, out_pc, illegal} !== '0) begin
            errors++;
            $display("FAIL ar_hold_reset: got req=%b addr=%h v=%b op=%b pc=%h ill=%b, want all 0",
                     imem_req, imem_addr, out_valid, opcode, out_pc, illegal);
        end
        auto_lat = 3; out_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (imem_req) begin found = 1'b1; break; end
        end
        checks++;
        if (!found || imem_addr !== 32'd0) begin
            errors++; $display("FAIL ar_restart: got req=%b addr=%h, want 1/0", found, imem_addr);
        end
        found = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h4) begin found = 1'b1; break; end
        end
        #1 rst_n = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (!found || {imem_req, imem_addr, out_valid, illegal} !== '0) begin
            errors++;
            $display("FAIL ar_fetch_reset: got found=%b req=%b addr=%h v=%b, want 1/0/0/0",
                     found, imem_req, imem_addr, out_valid);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        drain_and_check("areset");
    endtask

    task automatic test_redirect_coincident();
        bit found = 1'b0;
        fill_mem();
        auto_on = 1'b1; auto_lat = 0; auto_limit = 32'h4; out_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h4 && out_valid) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL rc_setup: got timeout, want slot full with request to 0x4");
        end
        @(posedge clk);
        #1 man_valid = 1'b1; redirect = 1'b1; redirect_pc = 32'h80; out_ready = 1'b1;
        @(posedge clk);
        #1 man_valid = 1'b0; redirect = 1'b0; auto_limit = '1;
        @(negedge clk);
        checks++;
        if ({out_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h80}) begin
            errors++;
            $display("FAIL rc_no_drain: got v=%b req=%b addr=%h, want 0/1/80",
                     out_valid, imem_req, imem_addr);
        end
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) begin found = (out_pc == 32'h80); break; end
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL rc_target_issue: got pc=%h, want 80", out_pc);
        end
        drain_and_check("coincident");
    endtask

    initial begin
        fill_mem();
        test_reset();
        test_basic();
        test_stall();
        test_redirect_drain();
        test_illegal();
        test_async_reset();
        test_redirect_coincident();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want bench completion");
        $fatal(1);
    end

endmodule

// File: doc/fetch_issue_unit.md
Name: fetch_issue_unit

Overview:
- Instruction-fetch and issue stage. Owns the PC and requests instruction words from instruction memory over a request/valid handshake.
- Presents decoded instruction fields to the decode stage, with `opcode` driving the control unit's opcode input.
- Accepts a redirect (taken jump/branch) back from execute, flushes wrong-path work, and forces NOP (6'b000000) whenever no valid instruction is issued.

Parameters:
- ADDR_W, 32, PC and imem address width.
- INSTR_W, 32, instruction word width; opcode is always bits [INSTR_W-1 -: 6].
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, PC increment per sequential fetch (byte addressing).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; held high until imem_valid.
- imem_addr  out  ADDR_W  fetch address; stable while imem_req=1.
- imem_rdata  in  INSTR_W  returned instruction word.
- imem_valid  in  1  one-cycle pulse; imem_rdata valid; only legal while a request is outstanding.
- redirect  in  1  taken control transfer from execute.
- redirect_pc  in  ADDR_W  target address for redirect.
- out_ready  in  1  decode stage accepts the issued instruction this cycle.
- out_valid  out  1  issue slot holds a valid instruction.
- opcode  out  6  to control unit; 6'b000000 whenever out_valid=0.
- rd, rs1, rs2  out  5 each  instr[25:21], [20:16], [15:11]; zero when out_valid=0.
- imm_raw  out  16  instr[15:0], unextended (control unit imm_src selects extension downstream); zero when out_valid=0.
- out_pc  out  ADDR_W  address of the issued instruction.
- illegal  out  1  issued word carried an undefined opcode and was replaced by NOP.

Behaviour:
- Reset (async assert, sync release), applies immediately mid-operation and abandons any outstanding request:
  - pc=RESET_PC, state=IDLE.
  - imem_req=0, imem_addr=RESET_PC.
  - out_valid=0, opcode=0, rd/rs1/rs2/imm_raw=0, out_pc=RESET_PC, illegal=0.
  - Hold buffer empty.
- States: IDLE, FETCH, HOLD, DRAIN.
- IDLE: the first cycle after reset release -> FETCH with imem_req=1, imem_addr=pc.
- FETCH:
  - On imem_valid with the slot free (out_valid=0, or out_valid&out_ready): load the slot and set out_valid=1, out_pc=pc. Then pc<=pc+PC_STEP, and issue the next request the following cycle. This gives a 1-cycle bubble between requests; zero-wait memory yields one instruction per 2 cycles.
  - On imem_valid with the slot full and not consumed: capture word and pc in the hold buffer, set pc<=pc+PC_STEP, go to HOLD, imem_req=0.
- HOLD: imem_req=0. When out_ready=1, the hold buffer moves into the slot in the same cycle the old slot is consumed, then -> FETCH.
- Slot consumption: out_valid&out_ready with nothing loading clears out_valid the next cycle. Otherwise fields remain stable while out_valid&!out_ready.
- Redirect has top priority in any state except reset:
  - Next cycle: pc=redirect_pc, out_valid=0, hold buffer cleared, illegal=0.
  - If a request is outstanding (FETCH, imem_valid not in the same cycle): go to DRAIN. Otherwise go to FETCH at redirect_pc.
  - DRAIN: imem_req=0; discard the next imem_valid, then -> FETCH.
  - redirect coincident with imem_valid: discard that word, go directly to FETCH.
  - A second redirect in DRAIN updates pc only.
- Opcode legality check, applied on load into the slot:
  - Legal set: 000000, 000001, 001001, 000010, 001010, 000011, 001011, 000100, 001100, 010001, 011001, 010010, 011010, 010011, 010100, 101001, 101010, 101011, 111000–111110.
  - Any other opcode: slot loads opcode=000000 and zero fields, illegal=1, out_valid=1, out_pc kept.
  - illegal tracks the slot contents.
- PC arithmetic is modulo 2^ADDR_W; pc wraps from all-ones-aligned to 0 silently.
- imem_valid in IDLE or HOLD is a protocol violation and is ignored.

Test Plan:
- Reset, then release, imem 0-wait returning 0x04221800 (ADD r1,r2,r3), out_ready=1 -> imem_addr 0,4,8; out_valid rises with opcode=000001, rd=1, rs1=2, rs2=3, out_pc=0.
- out_ready=0 for 6 cycles across two returned words -> first stays on outputs, second goes to HOLD, imem_req=0. Raise out_ready -> second word issues next cycle, out_pc=4, no word lost or duplicated.
- Redirect with redirect_pc=0x40 while a request to 0x8 is outstanding, imem_valid 3 cycles later -> that word dropped, out_valid=0, next imem_addr=0x40.
- imem returns opcode 6'b111111 -> opcode=000000, illegal=1, out_valid=1; next legal word clears illegal.
- Assert rst_n=0 mid-FETCH with slot and hold full -> all outputs immediately at reset values; after release fetch restarts at RESET_PC.
- Redirect coincident with imem_valid and out_valid&out_ready -> slot empty next cycle, FETCH at redirect_pc with no DRAIN.
